// File: rtl/k_and_s_pkg.sv
//------------------------------------------------------------------------------
// k_and_s_pkg : shared types for the K&S control unit and datapath.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_BRANCH = 5'd8,
      I_BZERO  = 5'd9,
      I_BNZERO = 5'd10,
      I_BNEG   = 5'd11,
      I_BNNEG  = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_HALT   = 5'd15
   } decoded_instruction_type;

   typedef enum logic [1:0] {
      ALU_OR  = 2'b00,
      ALU_ADD = 2'b01,
      ALU_SUB = 2'b10,
      ALU_AND = 2'b11
   } alu_op_t;

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_FETCH       = 4'd1,
      S_LOAD_IR     = 4'd2,
      S_DECODE      = 4'd3,
      S_EXEC_ALU    = 4'd4,
      S_EXEC_MOVE   = 4'd5,
      S_LOAD_WAIT   = 4'd6,
      S_LOAD_WB     = 4'd7,
      S_STORE       = 4'd8,
      S_BRANCH_TAKE = 4'd9,
      S_HALTED      = 4'd10
   } cu_state_t;

   function automatic alu_op_t alu_op_of(input decoded_instruction_type ins);
      case (ins)
         I_ADD:   return ALU_ADD;
         I_SUB:   return ALU_SUB;
         I_AND:   return ALU_AND;
         default: return ALU_OR;
      endcase
   endfunction

   function automatic logic branch_taken(input decoded_instruction_type ins,
                                         input logic zero, input logic neg,
                                         input logic sovf);
      case (ins)
         I_BRANCH: return 1'b1;
         I_BZERO:  return zero;
         I_BNZERO: return !zero;
         I_BNEG:   return neg;
         I_BNNEG:  return !neg;
         I_BOV:    return sovf;
         I_BNOV:   return !sovf;
         default:  return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/cu_wait_timer.sv
//------------------------------------------------------------------------------
// cu_wait_timer : RAM_LATENCY-cycle down-counter; o_done marks the last wait cycle.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cu_wait_timer #(
   parameter int RAM_LATENCY = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_run,
   output logic o_done
);

   localparam int c_cnt_w = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
   localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(RAM_LATENCY - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // Reloaded on every state entry so each waiting state sees a full count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= c_load;
      end else if (i_clear) begin
         r_cnt <= c_load;
      end else if (i_run && (r_cnt != '0)) begin
         r_cnt <= r_cnt - c_cnt_w'(1);
      end
   end

   assign o_done = i_run && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// multicycle_control_unit : Moore FSM sequencing fetch/decode/execute for K&S.
// Optional CU_SINGLE_STEP_EN adds i_step and an IDLE gate before every FETCH.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit
   import k_and_s_pkg::*;
#(
   parameter int RAM_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef CU_SINGLE_STEP_EN
   input  logic                    i_step,
`endif
   input  decoded_instruction_type i_decoded_instruction,
   input  logic                    i_zero_op,
   input  logic                    i_neg_op,
   input  logic                    i_unsigned_overflow,
   input  logic                    i_signed_overflow,
   output logic                    o_branch,
   output logic                    o_pc_enable,
   output logic                    o_ir_enable,
   output logic                    o_write_reg_enable,
   output logic                    o_addr_sel,
   output logic                    o_c_sel,
   output alu_op_t                 o_operation,
   output logic                    o_flags_reg_enable,
   output logic                    o_ram_write_enable,
   output logic                    o_halt,
   output logic [CNT_W-1:0]        o_instr_retired
);

   generate
      if (RAM_LATENCY < 1) begin : g_bad_latency
         $error("multicycle_control_unit: RAM_LATENCY must be >= 1");
      end
   endgenerate

`ifdef CU_SINGLE_STEP_EN
   localparam cu_state_t c_reset_state = S_IDLE;
   localparam cu_state_t c_after_instr = S_IDLE;
`else
   localparam cu_state_t c_reset_state = S_FETCH;
   localparam cu_state_t c_after_instr = S_FETCH;
`endif

   cu_state_t               r_state;
   cu_state_t               w_next;
   decoded_instruction_type r_instr;
   logic [CNT_W-1:0]        r_retired;
   logic                    w_retire;
   logic                    w_wait_run;
   logic                    w_wait_done;
   logic                    w_taken;
   logic                    w_unused_carry;

   assign w_unused_carry = i_unsigned_overflow;
   assign w_wait_run     = (r_state == S_FETCH) || (r_state == S_LOAD_WAIT);
   assign w_taken        = branch_taken(i_decoded_instruction, i_zero_op,
                                        i_neg_op, i_signed_overflow);

   cu_wait_timer #(
      .RAM_LATENCY(RAM_LATENCY)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (w_next != r_state),
      .i_run   (w_wait_run),
      .o_done  (w_wait_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_reset_state;
         r_instr   <= I_NOP;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_instr <= i_decoded_instruction;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next             = r_state;
      w_retire           = 1'b0;
      o_branch           = 1'b0;
      o_pc_enable        = 1'b0;
      o_ir_enable        = 1'b0;
      o_write_reg_enable = 1'b0;
      o_addr_sel         = 1'b0;
      o_c_sel            = 1'b0;
      o_operation        = ALU_OR;
      o_flags_reg_enable = 1'b0;
      o_ram_write_enable = 1'b0;
      o_halt             = 1'b0;
      case (r_state)
`ifdef CU_SINGLE_STEP_EN
         S_IDLE: begin
            if (i_step) w_next = S_FETCH;
         end
`endif
         S_FETCH: begin
            if (w_wait_done) w_next = S_LOAD_IR;
         end
         S_LOAD_IR: begin
            o_ir_enable = 1'b1;
            o_pc_enable = 1'b1;
            w_next      = S_DECODE;
         end
         S_DECODE: begin
            case (i_decoded_instruction)
               I_ADD, I_SUB, I_AND, I_OR: w_next = S_EXEC_ALU;
               I_MOVE:                    w_next = S_EXEC_MOVE;
               I_LOAD:                    w_next = S_LOAD_WAIT;
               I_STORE:                   w_next = S_STORE;
               I_HALT: begin
                  w_next   = S_HALTED;
                  w_retire = 1'b1;
               end
               I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                  w_next   = w_taken ? S_BRANCH_TAKE : c_after_instr;
                  w_retire = !w_taken;
               end
               default: begin
                  w_next   = c_after_instr;
                  w_retire = 1'b1;
               end
            endcase
         end
         S_EXEC_ALU: begin
            o_operation        = alu_op_of(r_instr);
            o_write_reg_enable = 1'b1;
            o_flags_reg_enable = 1'b1;
            w_next             = c_after_instr;
            w_retire           = 1'b1;
         end
         // Datapath forces B to zero, so OR passes A through unchanged.
         S_EXEC_MOVE: begin
            o_operation        = ALU_OR;
            o_write_reg_enable = 1'b1;
            w_next             = c_after_instr;
            w_retire           = 1'b1;
         end
         S_LOAD_WAIT: begin
            o_addr_sel = 1'b1;
            if (w_wait_done) w_next = S_LOAD_WB;
         end
         S_LOAD_WB: begin
            o_addr_sel         = 1'b1;
            o_c_sel            = 1'b1;
            o_write_reg_enable = 1'b1;
            w_next             = c_after_instr;
            w_retire           = 1'b1;
         end
         S_STORE: begin
            o_addr_sel         = 1'b1;
            o_ram_write_enable = 1'b1;
            w_next             = c_after_instr;
            w_retire           = 1'b1;
         end
         S_BRANCH_TAKE: begin
            o_branch    = 1'b1;
            o_pc_enable = 1'b1;
            w_next      = c_after_instr;
            w_retire    = 1'b1;
         end
         S_HALTED: begin
            o_halt = 1'b1;
         end
         default: begin
            w_next = c_after_instr;
         end
      endcase
   end

   assign o_instr_retired = r_retired;

endmodule

`default_nettype wire
